stacker_ctrl: RTL and testbench
===============================

STACKER_CTRL -- requirements
Module: stacker_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, meaning playfield width in pixels.
REQ-002 SHALL have parameter ROW_H, default 8, meaning row height in pixels.
REQ-003 SHALL have parameter NUM_ROWS, default 15, meaning rows needed to win.
REQ-004 SHALL have parameter INIT_W, default 32, meaning starting block width in pixels.
REQ-005 SHALL have parameters DELAY_INIT/DELAY_STEP/DELAY_MIN, defaults 24'd833333/24'd50000/24'd100000, meaning tick-period reload control in clocks.
REQ-006 SHALL have ports `clk` (in, 1, sole clock) and `resetn` (in, 1, reset); one clock; reset is asynchronous and active-high.
REQ-007 SHALL have `start` in 1 (begin/restart game) and `stop_btn` in 1 (player lock request, asynchronous).
REQ-008 SHALL have `draw_req` out 1, `draw_done` in 1, `draw_x` out 8, `draw_y` out 7, `draw_w` out 8, `draw_erase` out 1: rectangle draw handshake to the plot datapath.
REQ-009 SHALL have `row_idx` out 4 (current row), `game_over` out 1, `game_win` out 1, `state_dbg` out 4 (state encoding, for LEDs).

Function
REQ-010 SHALL implement states IDLE, ARM, DRAW, TICK, ERASE, MOVE, LOCK, TRIM_ERASE, TRIM_DRAW, NEXT_ROW, LOSE, WIN.
REQ-011 SHALL use these transitions:
- IDLE->ARM on start=1.
- ARM->DRAW on start=0.
- DRAW->TICK on draw_done.
- TICK->LOCK if a stop is pending; otherwise TICK->ERASE on counter expiry.
- ERASE->MOVE on draw_done.
- MOVE->DRAW.
- LOCK->LOSE on zero overlap; otherwise LOCK->TRIM_ERASE.
- TRIM_ERASE->TRIM_DRAW on draw_done.
- TRIM_DRAW->NEXT_ROW on draw_done.
- NEXT_ROW->WIN if row_idx==NUM_ROWS-1; otherwise NEXT_ROW->DRAW.
- LOSE/WIN->ARM on start=1.
REQ-012 SHALL assert draw_req throughout DRAW/ERASE/TRIM_ERASE/TRIM_DRAW until draw_done is sampled high, deasserting the following cycle; draw_x/y/w/erase SHALL be stable while draw_req=1.
REQ-013 SHALL set draw_erase=1 in ERASE and TRIM_ERASE only.
REQ-014 SHALL drive draw_y=(NUM_ROWS-1-row_idx)*ROW_H.
REQ-015 SHALL move the block in MOVE by 1 pixel in the current direction.
REQ-016 SHALL bounce at the edges: moving right with x+w==SCREEN_W flips direction and decrements x; moving left with x==0 flips direction and increments x.
REQ-017 SHALL synchronise stop_btn through 2 flops, detect its rising edge, and hold a pending flag until consumed in LOCK; a press during ERASE/MOVE/DRAW SHALL be honoured at the next TICK.
REQ-018 SHALL compute the LOCK overlap against the previous row's (px,pw):
- For row 0, the previous row is (0,SCREEN_W).
- L=max(x,px), R=min(x+w,px+pw).
- R<=L means zero overlap -> LOSE.
- Otherwise the trimmed block is x=L, w=R-L.
REQ-019 SHALL, in TRIM_ERASE, erase the untrimmed extent, then draw the trimmed block in TRIM_DRAW.
REQ-020 SHALL, in NEXT_ROW:
- store the locked (x,w) as (px,pw);
- increment row_idx;
- keep w;
- set x=0 and direction=right;
- reload the tick period to max(DELAY_MIN, period-DELAY_STEP).
REQ-021 SHALL use 9-bit internal width for x+w so no sum wraps; all widths SHALL be unsigned.
REQ-022 SHALL initialise the game in ARM: row_idx=0, x=0, w=INIT_W, period=DELAY_INIT, pending stop cleared.
REQ-023 SHALL hold game_over=1 only in LOSE and game_win=1 only in WIN.
REQ-024 SHALL give a stop arriving in the same cycle as tick expiry priority (TICK->LOCK).

Reset
REQ-025 SHALL, while resetn=1, asynchronously force state IDLE and all outputs to 0, including draw_req=0, row_idx=0 and state_dbg=0; this SHALL abort any in-flight draw without waiting for draw_done.
REQ-026 SHALL resume at IDLE after reset release.

Structure
REQ-027 SHALL place the state enum and the default parameter constants in shared package stacker_pkg.
REQ-028 SHALL instantiate one sub-module, stacker_tick_counter: a loadable down-counter with reload, enable and expiry outputs.

Verification
REQ-029 SHALL cover: SCREEN_W=160, INIT_W=32, no stop -> x sweeps 0..128, flips direction at 128, returns to 0, flips again.
REQ-030 SHALL cover: row 0 locked at x=40 -> row 1 starts with px=40, pw=32, w=32, draw_y=(NUM_ROWS-2)*ROW_H.
REQ-031 SHALL cover: row 1 locked at x=50 over (40,32) -> trimmed x=50, w=22; then TRIM_ERASE(50,32) followed by TRIM_DRAW(50,22).
REQ-032 SHALL cover: row 1 locked at x=72 over (40,32) -> LOSE, game_over=1; start -> ARM, row_idx=0.
REQ-033 SHALL cover: NUM_ROWS=3 with perfect stops -> WIN after 3 locks; periods go 833333, 783333, 733333.
REQ-034 SHALL cover: resetn pulsed while draw_req=1 in ERASE -> draw_req=0 immediately, state_dbg=IDLE.

Source files
------------

// File: rtl/stacker_pkg.sv
// Shared types and default constants for the stacker game controller.
package stacker_pkg;

  // Controller states; the numeric encoding is exported on state_dbg.
  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StArm       = 4'd1,
    StDraw      = 4'd2,
    StTick      = 4'd3,
    StErase     = 4'd4,
    StMove      = 4'd5,
    StLock      = 4'd6,
    StTrimErase = 4'd7,
    StTrimDraw  = 4'd8,
    StNextRow   = 4'd9,
    StLose      = 4'd10,
    StWin       = 4'd11
  } state_e;

  typedef enum logic {
    DirRight = 1'b0,
    DirLeft  = 1'b1
  } dir_e;

  localparam int unsigned DefaultScreenW   = 160;
  localparam int unsigned DefaultRowH      = 8;
  localparam int unsigned DefaultNumRows   = 15;
  localparam int unsigned DefaultInitW     = 32;
  localparam logic [23:0] DefaultDelayInit = 24'd833333;
  localparam logic [23:0] DefaultDelayStep = 24'd50000;
  localparam logic [23:0] DefaultDelayMin  = 24'd100000;

endpackage

// File: rtl/stacker_tick_counter.sv
// Loadable down-counter that paces block movement.
module stacker_tick_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [23:0] load_val_i,
  input  logic        en_i,
  output logic        expired_o
);

  logic [23:0] count_q, count_d;

  // Reload has priority; otherwise count down while enabled, holding at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != 24'd0)) begin
      count_d = count_q - 24'd1;
    end
  end

  assign expired_o = en_i && (count_q == 24'd0);

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 24'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stacker_ctrl.sv
// Stacker game controller: sweeps a block, locks it on a stop press, trims it
// against the row below and requests rectangle draws from the plot datapath.
module stacker_ctrl
  import stacker_pkg::*;
#(
  parameter int unsigned SCREEN_W   = DefaultScreenW,
  parameter int unsigned ROW_H      = DefaultRowH,
  parameter int unsigned NUM_ROWS   = DefaultNumRows,
  parameter int unsigned INIT_W     = DefaultInitW,
  parameter logic [23:0] DELAY_INIT = DefaultDelayInit,
  parameter logic [23:0] DELAY_STEP = DefaultDelayStep,
  parameter logic [23:0] DELAY_MIN  = DefaultDelayMin
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       stop_btn,
  output logic       draw_req,
  input  logic       draw_done,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  output logic [7:0] draw_w,
  output logic       draw_erase,
  output logic [3:0] row_idx,
  output logic       game_over,
  output logic       game_win,
  output logic [3:0] state_dbg
);

  localparam logic [8:0] ScreenW9 = 9'(SCREEN_W);
  localparam logic [7:0] ScreenW8 = 8'(SCREEN_W);
  localparam logic [7:0] InitW8   = 8'(INIT_W);
  localparam logic [3:0] LastRow  = 4'(NUM_ROWS - 1);
  localparam logic [6:0] TopRow7  = 7'(NUM_ROWS - 1);
  localparam logic [6:0] RowH7    = 7'(ROW_H);

  state_e      state_q, state_d;
  dir_e        dir_q, dir_d;
  logic [7:0]  x_q, x_d, w_q, w_d, px_q, px_d, pw_q, pw_d, tx_q, tx_d, tw_q, tw_d;
  logic [3:0]  row_q, row_d;
  logic [23:0] period_q, period_d;
  logic        pending_q, pending_d, ack_q, ack_d;
  logic        stop_meta_q, stop_sync_q, stop_prev_q;

  logic        stop_rise, draw_state, done_hs;
  logic        tick_load, tick_en, tick_expired;
  logic [23:0] tick_reload, period_dec, period_next;
  logic [8:0]  x_end, p_end, ov_hi;
  logic [7:0]  ov_lo;
  logic        ov_none;

  assign stop_rise  = stop_sync_q & ~stop_prev_q;
  assign draw_state = (state_q == StDraw) || (state_q == StErase) ||
                      (state_q == StTrimErase) || (state_q == StTrimDraw);
  // ack_q forces a one-cycle gap after each accepted draw, so back-to-back
  // draw states still present a fresh request edge.
  assign draw_req   = draw_state && !ack_q;
  assign done_hs    = draw_req && draw_done;

  assign tick_load   = (state_q == StDraw) && done_hs;
  assign tick_en     = (state_q == StTick);
  assign tick_reload = period_q - 24'd1;

  stacker_tick_counter u_tick (
    .clk_i      (clk),
    .rst_i      (resetn),
    .load_i     (tick_load),
    .load_val_i (tick_reload),
    .en_i       (tick_en),
    .expired_o  (tick_expired)
  );

  // Overlap of the moving block with the previous row, and the next tick period.
  always_comb begin
    x_end       = {1'b0, x_q} + {1'b0, w_q};
    p_end       = {1'b0, px_q} + {1'b0, pw_q};
    ov_lo       = (x_q > px_q) ? x_q : px_q;
    ov_hi       = (x_end < p_end) ? x_end : p_end;
    ov_none     = (ov_hi <= {1'b0, ov_lo});
    period_dec  = (period_q > DELAY_STEP) ? (period_q - DELAY_STEP) : 24'd0;
    period_next = (period_dec > DELAY_MIN) ? period_dec : DELAY_MIN;
  end

  // Rectangle outputs are zero outside draw states, including during reset.
  always_comb begin
    draw_x     = 8'd0;
    draw_y     = 7'd0;
    draw_w     = 8'd0;
    draw_erase = 1'b0;
    if (draw_state) begin
      draw_x     = (state_q == StTrimDraw) ? tx_q : x_q;
      draw_w     = (state_q == StTrimDraw) ? tw_q : w_q;
      draw_y     = (TopRow7 - {3'b000, row_q}) * RowH7;
      draw_erase = (state_q == StErase) || (state_q == StTrimErase);
    end
  end

  assign row_idx   = row_q;
  assign game_over = (state_q == StLose);
  assign game_win  = (state_q == StWin);
  assign state_dbg = state_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    x_d       = x_q;
    w_d       = w_q;
    px_d      = px_q;
    pw_d      = pw_q;
    tx_d      = tx_q;
    tw_d      = tw_q;
    row_d     = row_q;
    period_d  = period_q;
    pending_d = pending_q | stop_rise;
    ack_d     = done_hs;
    unique case (state_q)
      StIdle: if (start) state_d = StArm;
      StArm: begin
        row_d     = 4'd0;
        x_d       = 8'd0;
        w_d       = InitW8;
        dir_d     = DirRight;
        px_d      = 8'd0;
        pw_d      = ScreenW8;
        period_d  = DELAY_INIT;
        pending_d = 1'b0;
        if (!start) state_d = StDraw;
      end
      StDraw: if (done_hs) state_d = StTick;
      StTick: begin
        if (pending_q) begin
          state_d = StLock;
        end else if (tick_expired) begin
          state_d = StErase;
        end
      end
      StErase: if (done_hs) state_d = StMove;
      StMove: begin
        if (dir_q == DirRight) begin
          if (x_end == ScreenW9) begin
            dir_d = DirLeft;
            x_d   = x_q - 8'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
        end else begin
          if (x_q == 8'd0) begin
            dir_d = DirRight;
            x_d   = x_q + 8'd1;
          end else begin
            x_d = x_q - 8'd1;
          end
        end
        state_d = StDraw;
      end
      StLock: begin
        pending_d = stop_rise;
        if (ov_none) begin
          state_d = StLose;
        end else begin
          tx_d    = ov_lo;
          tw_d    = 8'(ov_hi - {1'b0, ov_lo});
          state_d = StTrimErase;
        end
      end
      StTrimErase: if (done_hs) state_d = StTrimDraw;
      StTrimDraw: begin
        if (done_hs) begin
          x_d     = tx_q;
          w_d     = tw_q;
          state_d = StNextRow;
        end
      end
      StNextRow: begin
        px_d     = x_q;
        pw_d     = w_q;
        row_d    = row_q + 4'd1;
        x_d      = 8'd0;
        dir_d    = DirRight;
        period_d = period_next;
        state_d  = (row_q == LastRow) ? StWin : StDraw;
      end
      StLose, StWin: if (start) state_d = StArm;
      default: state_d = StIdle;
    endcase
  end

  // State registers and the two-flop stop synchroniser.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q     <= StIdle;
      dir_q       <= DirRight;
      x_q         <= 8'd0;
      w_q         <= 8'd0;
      px_q        <= 8'd0;
      pw_q        <= 8'd0;
      tx_q        <= 8'd0;
      tw_q        <= 8'd0;
      row_q       <= 4'd0;
      period_q    <= 24'd0;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
      stop_meta_q <= 1'b0;
      stop_sync_q <= 1'b0;
      stop_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      x_q         <= x_d;
      w_q         <= w_d;
      px_q        <= px_d;
      pw_q        <= pw_d;
      tx_q        <= tx_d;
      tw_q        <= tw_d;
      row_q       <= row_d;
      period_q    <= period_d;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
      stop_meta_q <= stop_btn;
      stop_sync_q <= stop_meta_q;
      stop_prev_q <= stop_sync_q;
    end
  end

endmodule

// File: tb/tb_stacker_ctrl.sv
// Self-checking bench for stacker_ctrl: a game-level model predicts every draw
// rectangle, tick period and end-of-game flag.
module tb_stacker_ctrl;

  localparam int unsigned SW = 160;
  localparam int unsigned RH = 8;
  localparam int unsigned NR = 3;
  localparam int unsigned IW = 32;
  localparam logic [23:0] DI = 24'd12;
  localparam logic [23:0] DS = 24'd4;
  localparam logic [23:0] DM = 24'd5;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic       stop_btn = 1'b0;
  logic       draw_done = 1'b0;
  logic       draw_req, draw_erase, game_over, game_win;
  logic [7:0] draw_x, draw_w;
  logic [6:0] draw_y;
  logic [3:0] row_idx, state_dbg;

  stacker_ctrl #(
    .SCREEN_W   (SW),
    .ROW_H      (RH),
    .NUM_ROWS   (NR),
    .INIT_W     (IW),
    .DELAY_INIT (DI),
    .DELAY_STEP (DS),
    .DELAY_MIN  (DM)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .stop_btn   (stop_btn),
    .draw_req   (draw_req),
    .draw_done  (draw_done),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_w     (draw_w),
    .draw_erase (draw_erase),
    .row_idx    (row_idx),
    .game_over  (game_over),
    .game_win   (game_win),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Game model: block width, previous row extent, row number, tick period.
  int m_w, m_px, m_pw, m_row, m_period;
  // Rectangle the DUT should be requesting right now.
  bit exp_valid = 1'b0;
  int exp_x, exp_y, exp_w, exp_erase, exp_row;
  // Last rectangle observed, plus per-row observations.
  int last_x, last_y, last_w;
  int first_y, row_max, meas_period, te_x, te_w, tr_x, tr_w;
  bit lost, won;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  task automatic finish_up();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // Block position after n moves in a row: a triangle wave bouncing over the
  // span of legal left edges.
  function automatic int x_at(input int n);
    int span;
    int t;
    span = int'(SW) - m_w;
    if (span <= 0) return 0;
    t = n % (2 * span);
    return (t <= span) ? t : (2 * span - t);
  endfunction

  // Every cycle with an outstanding request must show the predicted rectangle.
  always @(negedge clk) begin
    if (exp_valid && draw_req) begin
      check("draw_x", int'(draw_x), exp_x);
      check("draw_y", int'(draw_y), exp_y);
      check("draw_w", int'(draw_w), exp_w);
      check("draw_erase", int'(draw_erase), exp_erase);
      check("row_idx", int'(row_idx), exp_row);
      check("no_end_flag", int'(game_over | game_win), 0);
    end
  end

  task automatic wait_req(output int cycles);
    cycles = 0;
    while (!draw_req && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
    if (!draw_req) begin
      check("draw_req_timeout", 0, 1);
      finish_up();
    end
  endtask

  // Serve one draw request; gap is the number of request-free cycles before it.
  task automatic do_draw(input int ex, input int ew, input int ee, input bit press,
                         output int gap);
    exp_x     = ex;
    exp_w     = ew;
    exp_erase = ee;
    exp_row   = m_row;
    exp_y     = (int'(NR) - 1 - m_row) * int'(RH);
    exp_valid = 1'b1;
    wait_req(gap);
    last_x = int'(draw_x);
    last_y = int'(draw_y);
    last_w = int'(draw_w);
    if (press) begin
      stop_btn = 1'b1;
      repeat (5) @(negedge clk);
      stop_btn = 1'b0;
    end else begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
  endtask

  task automatic wait_flag(input string name, input bit want_win);
    int n;
    n = 0;
    while (n < 50 && !(want_win ? game_win : game_over)) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(want_win ? game_win : game_over), 1);
    check({name, "_other"}, int'(want_win ? game_over : game_win), 0);
  endtask

  task automatic start_game();
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("arm_row_idx", int'(row_idx), 0);
    check("arm_no_flags", int'(game_over | game_win), 0);
    start = 1'b0;
    m_row    = 0;
    m_px     = 0;
    m_pw     = int'(SW);
    m_w      = int'(IW);
    m_period = int'(DI);
  endtask

  // Sweep the block for `moves` moves, lock it, then follow the trim and row
  // advance or the loss.
  task automatic play_row(input int moves, output bit row_lost, output bit row_won);
    int gap, lx, lo, hi;
    row_lost    = 1'b0;
    row_won     = 1'b0;
    row_max     = 0;
    meas_period = -1;
    lx          = 0;
    for (int k = 0; k <= moves; k++) begin
      lx = x_at(k);
      do_draw(lx, m_w, 0, (k == moves), gap);
      if (k == 0) first_y = last_y;
      if (last_x > row_max) row_max = last_x;
      if (k < moves) begin
        do_draw(lx, m_w, 1, 1'b0, gap);
        check("tick_period", gap, m_period);
        meas_period = gap;
      end
    end
    lo = (lx > m_px) ? lx : m_px;
    hi = ((lx + m_w) < (m_px + m_pw)) ? (lx + m_w) : (m_px + m_pw);
    if (hi <= lo) begin
      row_lost  = 1'b1;
      exp_valid = 1'b0;
      wait_flag("game_over", 1'b0);
      return;
    end
    do_draw(lx, m_w, 1, 1'b0, gap);
    te_x = last_x;
    te_w = last_w;
    do_draw(lo, hi - lo, 0, 1'b0, gap);
    tr_x = last_x;
    tr_w = last_w;
    m_px     = lo;
    m_pw     = hi - lo;
    m_w      = hi - lo;
    m_row    = m_row + 1;
    m_period = ((m_period - int'(DS)) > int'(DM)) ? (m_period - int'(DS)) : int'(DM);
    if (m_row == int'(NR)) begin
      row_won   = 1'b1;
      exp_valid = 1'b0;
      wait_flag("game_win", 1'b1);
    end
  endtask

  initial begin
    int gap;
    m_w = int'(IW); m_px = 0; m_pw = int'(SW); m_row = 0; m_period = int'(DI);

    // Reset values, then idle after release.
    repeat (3) @(negedge clk);
    check("rst_draw_req", int'(draw_req), 0);
    check("rst_state", int'(state_dbg), 0);
    check("rst_row", int'(row_idx), 0);
    check("rst_flags", int'(game_over | game_win), 0);
    check("rst_rect", int'(draw_x) + int'(draw_y) + int'(draw_w) + int'(draw_erase), 0);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_rst", int'(state_dbg), 0);
    check("idle_no_req", int'(draw_req), 0);

    // Game 1: full bounce sweep, lock at 40, then 50, then a perfect stop.
    start_game();
    play_row(296, lost, won);
    check("g1_r0_max_x", row_max, 128);
    check("g1_r0_period", meas_period, 12);
    check("g1_r0_trim_x", tr_x, 40);
    check("g1_r0_trim_w", tr_w, 32);
    play_row(50, lost, won);
    check("g1_r1_y", first_y, 8);
    check("g1_r1_period", meas_period, 8);
    check("g1_r1_te_x", te_x, 50);
    check("g1_r1_te_w", te_w, 32);
    check("g1_r1_trim_x", tr_x, 50);
    check("g1_r1_trim_w", tr_w, 22);
    play_row(50, lost, won);
    check("g1_r2_period", meas_period, 5);
    check("g1_r2_trim_w", tr_w, 22);
    check("g1_won", int'(won), 1);

    // Game 2: row 1 locked fully right of row 0 loses.
    start_game();
    play_row(40, lost, won);
    play_row(72, lost, won);
    check("g2_lost", int'(lost), 1);
    check("g2_lose_row", int'(row_idx), 1);
    start_game();

    // Random games.
    for (int g = 0; g < 3; g++) begin
      for (int r = 0; r < int'(NR); r++) begin
        play_row(int'($urandom_range(0, 120)), lost, won);
        if (lost || won) break;
      end
      start_game();
    end

    // Reset while an erase request is outstanding.
    do_draw(0, int'(IW), 0, 1'b0, gap);
    exp_x = 0; exp_w = int'(IW); exp_erase = 1; exp_row = 0;
    exp_y = (int'(NR) - 1) * int'(RH);
    wait_req(gap);
    check("pre_rst_erase", int'(draw_erase), 1);
    exp_valid = 1'b0;
    #2 resetn = 1'b1;
    #1;
    check("abort_draw_req", int'(draw_req), 0);
    check("abort_state", int'(state_dbg), 0);
    check("abort_erase", int'(draw_erase), 0);
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("resume_idle", int'(state_dbg), 0);
    check("resume_no_req", int'(draw_req), 0);

    finish_up();
  end

endmodule
